// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for a 5-stage RISC-V pipeline.
// Merges load-use hazard, EX branch redirect and data-memory handshake into
// per-stage write enables and bubble flushes; runs a debug halt drain and a
// memory-timeout watchdog.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the saturating
// stall-cycle and branch-flush performance counters.
module pipeline_ctrl #(
    parameter int MAX_WAIT     = 15,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             halt_req_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             halted_o,
    output logic             mem_timeout_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    localparam int WAIT_W  = 8;
    localparam int DRAIN_W = 4;

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_MEM_WAIT = 3'd1,
        S_DRAIN    = 3'd2,
        S_HALTED   = 3'd3,
        S_ERROR    = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [DRAIN_W-1:0]   drain_cnt_reg, drain_cnt_next;
    logic                 freeze;
    // wr: {pc, if_id, id_ex, ex_mem, mem_wb}; fl: {if_id, id_ex}
    logic [4:0]           wr;
    logic [1:0]           fl;

    assign freeze = mem_req_i & ~mem_ready_i;

    // State, watchdog and drain counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_RUN;
            wait_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // Next-state and zero-latency enable/flush decode
    always_comb begin
        wr             = 5'b11111;
        fl             = 2'b00;
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        wait_cnt_next  = freeze ? wait_cnt_reg + 8'd1 : '0;

        case (state_reg)
            S_RUN, S_MEM_WAIT: begin
                if (freeze) begin
                    wr         = 5'b00000;
                    state_next = S_MEM_WAIT;
                end else if (branch_taken_i) begin
                    fl         = 2'b11;
                    state_next = S_RUN;
                end else if (hazard_i) begin
                    wr[4]      = 1'b0;
                    wr[3]      = 1'b0;
                    fl[0]      = 1'b1;
                    state_next = S_RUN;
                end else if (halt_req_i) begin
                    wr[4]          = 1'b0;
                    fl[1]          = 1'b1;
                    state_next     = S_DRAIN;
                    drain_cnt_next = 4'd1;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if (freeze) begin
                    wr = 5'b00000;
                end else begin
                    wr[4] = 1'b0;
                    fl[1] = 1'b1;
                    if (branch_taken_i) begin
                        // Let the redirect target into the PC, then restart the drain
                        wr[4]          = 1'b1;
                        fl[0]          = 1'b1;
                        drain_cnt_next = 4'd1;
                    end else if (hazard_i) begin
                        wr[3] = 1'b0;
                        fl[1] = 1'b0;
                        fl[0] = 1'b1;
                    end else if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES)) begin
                        state_next = S_HALTED;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + 4'd1;
                    end
                    // Abandoning the drain is safe: inserted bubbles are NOPs
                    if (!halt_req_i) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_HALTED: begin
                wr = 5'b00000;
                if (!halt_req_i) begin
                    state_next = S_RUN;
                end
            end
            S_ERROR: begin
                wr            = 5'b00000;
                wait_cnt_next = wait_cnt_reg;
            end
            default: begin
                wr         = 5'b00000;
                state_next = S_RUN;
            end
        endcase

        // Watchdog overrides every transition once the limit is reached
        if (state_reg != S_ERROR && freeze && wait_cnt_reg == WAIT_W'(MAX_WAIT - 1)) begin
            state_next = S_ERROR;
        end

        // Hold the pipeline empty while in reset
        if (!rst_n) begin
            wr = 5'b00000;
            fl = 2'b11;
        end
    end

    assign pc_write_o     = wr[4];
    assign if_id_write_o  = wr[3];
    assign id_ex_write_o  = wr[2];
    assign ex_mem_write_o = wr[1];
    assign mem_wb_write_o = wr[0];
    assign if_id_flush_o  = fl[1];
    assign id_ex_flush_o  = fl[0];
    assign halted_o       = (state_reg == S_HALTED);
    assign mem_timeout_o  = (state_reg == S_ERROR);
    assign state_o        = state_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic             active;
    logic [1:0]       evt;
    logic [CNT_W-1:0] cnt_reg [2];

    assign active = (state_reg == S_RUN) || (state_reg == S_MEM_WAIT) || (state_reg == S_DRAIN);
    // evt[0]: stall cycle, evt[1]: branch-caused flush
    assign evt[0] = rst_n & active & ~wr[4];
    assign evt[1] = rst_n & active & ~freeze & branch_taken_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        // Saturating event counter, cleared only by reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg[gi] <= '0;
            end else if (evt[gi] && cnt_reg[gi] != {CNT_W{1'b1}}) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end

    assign stall_cycles_o = cnt_reg[0];
    assign flush_events_o = cnt_reg[1];
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each step pushes the expected
// {writes, flushes, halted, timeout, state} vector and pops it at the
// following negedge once the combinational outputs have settled.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hazard = 1'b0, branch = 1'b0, req = 1'b0, ready = 1'b0, halt = 1'b0;
    logic             pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, halted, timeout;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic rn, br, hz, rq, rd, hl;
        logic [11:0] e;
    } step_t;

    logic [11:0] exp_q[$];
    logic [11:0] obs;

    pipeline_ctrl #(.MAX_WAIT(15), .DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hazard_i(hazard), .branch_taken_i(branch),
        .mem_req_i(req), .mem_ready_i(ready), .halt_req_i(halt),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .id_ex_write_o(idex_w),
        .ex_mem_write_o(exmem_w), .mem_wb_write_o(memwb_w),
        .if_id_flush_o(ifid_f), .id_ex_flush_o(idex_f),
        .halted_o(halted), .mem_timeout_o(timeout), .state_o(state),
        .stall_cycles_o(stall_cnt), .flush_events_o(flush_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, halted, timeout, state};

    localparam logic [4:0] W  = 5'b11111;
    localparam logic [4:0] DR = 5'b01111;
    localparam logic [4:0] HZ = 5'b00111;
    localparam logic [4:0] Z  = 5'b00000;

    function automatic logic [11:0] ev(logic [4:0] w, logic [1:0] f, logic h, logic t, logic [2:0] s);
        return {w, f, h, t, s};
    endfunction

    function automatic step_t mk(logic rn, logic br, logic hz, logic rq, logic rd, logic hl, logic [11:0] e);
        step_t s;
        s.rn = rn; s.br = br; s.hz = hz; s.rq = rq; s.rd = rd; s.hl = hl; s.e = e;
        return s;
    endfunction

    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        rst_n = s.rn; branch = s.br; hazard = s.hz; req = s.rq; ready = s.rd; halt = s.hl;
        exp_q.push_back(s.e);
    endtask

    task automatic test_reset;
        step_t s[$];
        logic [11:0] e;
        s.push_back(mk(0, 0, 0, 0, 0, 0, ev(Z, 2'b11, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs, e);
            end
            $display("reset step %0d: out=%b", i, obs);
        end
        compared++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            mismatched++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use;
        step_t s[$];
        logic [11:0] e;
        s.push_back(mk(1, 0, 1, 0, 0, 0, ev(HZ, 2'b01, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL load_use step %0d: got %b expected %b", i, obs, e);
            end
            $display("load_use step %0d: out=%b", i, obs);
        end
    endtask

    task automatic test_mem_stall;
        step_t s[$];
        logic [11:0] e;
        s.push_back(mk(1, 0, 0, 1, 0, 0, ev(Z, 2'b00, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 1, 0, 0, ev(Z, 2'b00, 0, 0, 1)));
        s.push_back(mk(1, 0, 0, 1, 0, 0, ev(Z, 2'b00, 0, 0, 1)));
        s.push_back(mk(1, 0, 0, 1, 1, 0, ev(W, 2'b00, 0, 0, 1)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL mem_stall step %0d: got %b expected %b", i, obs, e);
            end
            $display("mem_stall step %0d: out=%b", i, obs);
        end
    endtask

    task automatic test_timeout;
        step_t s[$];
        logic [11:0] e;
        for (int k = 0; k < 15; k++)
            s.push_back(mk(1, 0, 0, 1, 0, 0, ev(Z, 2'b00, 0, 0, (k == 0) ? 3'd0 : 3'd1)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(Z, 2'b00, 0, 1, 4)));
        s.push_back(mk(1, 1, 0, 0, 0, 1, ev(Z, 2'b00, 0, 1, 4)));
        s.push_back(mk(1, 0, 1, 1, 1, 0, ev(Z, 2'b00, 0, 1, 4)));
        s.push_back(mk(0, 0, 0, 0, 0, 0, ev(Z, 2'b11, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL timeout step %0d: got %b expected %b", i, obs, e);
            end
            $display("timeout step %0d: out=%b", i, obs);
        end
    endtask

    task automatic test_halt;
        step_t s[$];
        logic [11:0] e;
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(DR, 2'b10, 0, 0, 0)));
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1, 0, 0, 0, 0, 1, ev(DR, 2'b10, 0, 0, 2)));
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(Z, 2'b00, 1, 0, 3)));
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(Z, 2'b00, 1, 0, 3)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(Z, 2'b00, 1, 0, 3)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        // Aborted drain
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(DR, 2'b10, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(DR, 2'b10, 0, 0, 2)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(DR, 2'b10, 0, 0, 2)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL halt step %0d: got %b expected %b", i, obs, e);
            end
            $display("halt step %0d: out=%b", i, obs);
        end
    endtask

    task automatic test_drain_events;
        step_t s[$];
        logic [11:0] e;
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(DR, 2'b10, 0, 0, 0)));
        s.push_back(mk(1, 1, 0, 0, 0, 1, ev(W, 2'b11, 0, 0, 2)));
        s.push_back(mk(1, 0, 1, 0, 0, 1, ev(HZ, 2'b01, 0, 0, 2)));
        s.push_back(mk(1, 0, 0, 1, 0, 1, ev(Z, 2'b00, 0, 0, 2)));
        for (int k = 0; k < 4; k++)
            s.push_back(mk(1, 0, 0, 0, 0, 1, ev(DR, 2'b10, 0, 0, 2)));
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(Z, 2'b00, 1, 0, 3)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(Z, 2'b00, 1, 0, 3)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL drain_events step %0d: got %b expected %b", i, obs, e);
            end
            $display("drain_events step %0d: out=%b", i, obs);
        end
    endtask

    task automatic test_simultaneous;
        step_t s[$];
        logic [11:0] e;
        s.push_back(mk(1, 1, 1, 1, 0, 0, ev(Z, 2'b00, 0, 0, 0)));
        s.push_back(mk(1, 1, 1, 1, 1, 0, ev(W, 2'b11, 0, 0, 1)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL simultaneous step %0d: got %b expected %b", i, obs, e);
            end
            $display("simultaneous step %0d: out=%b", i, obs);
        end
    endtask

    task automatic test_back_to_back;
        step_t s[$];
        logic [11:0] e;
        s.push_back(mk(1, 1, 0, 0, 0, 0, ev(W, 2'b11, 0, 0, 0)));
        s.push_back(mk(1, 1, 0, 0, 0, 0, ev(W, 2'b11, 0, 0, 0)));
        s.push_back(mk(1, 0, 1, 0, 0, 0, ev(HZ, 2'b01, 0, 0, 0)));
        s.push_back(mk(1, 1, 0, 0, 0, 1, ev(W, 2'b11, 0, 0, 0)));
        s.push_back(mk(1, 0, 1, 0, 0, 1, ev(HZ, 2'b01, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 0, 0, 1, ev(DR, 2'b10, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(DR, 2'b10, 0, 0, 2)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, obs, e);
            end
            $display("back_to_back step %0d: out=%b", i, obs);
        end
    endtask

    task automatic test_perf_counters;
        logic [CNT_W-1:0] exp_stall, exp_flush;
        drive(mk(0, 0, 0, 0, 0, 0, ev(Z, 2'b11, 0, 0, 0)));
        @(negedge clk);
        void'(exp_q.pop_front());
        for (int k = 0; k < 20; k++) begin
            drive(mk(1, 0, 1, 0, 0, 0, ev(HZ, 2'b01, 0, 0, 0)));
            @(negedge clk);
            void'(exp_q.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 1, 0, 0, 0, 0, ev(W, 2'b11, 0, 0, 0)));
            @(negedge clk);
            void'(exp_q.pop_front());
        end
        drive(mk(1, 0, 0, 0, 0, 0, ev(W, 2'b00, 0, 0, 0)));
        @(negedge clk);
        void'(exp_q.pop_front());
`ifdef PIPE_CTRL_PERF_EN
        exp_stall = 4'd15;
        exp_flush = 4'd3;
`else
        exp_stall = '0;
        exp_flush = '0;
`endif
        compared++;
        if (stall_cnt !== exp_stall) begin
            mismatched++;
            $display("FAIL stall_cycles: got %0d expected %0d", stall_cnt, exp_stall);
        end
        compared++;
        if (flush_cnt !== exp_flush) begin
            mismatched++;
            $display("FAIL flush_events: got %0d expected %0d", flush_cnt, exp_flush);
        end
        $display("perf: stall=%0d flush=%0d", stall_cnt, flush_cnt);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_stall();
        test_timeout();
        test_halt();
        test_drain_events();
        test_simultaneous();
        test_back_to_back();
        test_perf_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
